instr_dispatch: RTL and testbench
=================================

Name: instr_dispatch

Overview:
Instruction sequencer that sits on the initiator side of the unit start/done handshake. Execution units such as the register-move unit are responders to it.
- Fetches 16-bit words from a synchronous program memory and decodes an opcode plus two 6-bit operand fields.
- Raises a held start to the selected unit and drives parameter1/parameter2 to it.
- Waits for that unit's done, then pulses donefetch to clear all units and advances the PC.

Parameters:
PC_W, 8, program counter / imem address width
NUNITS, 4, number of execution units; valid range 1..14
TMO_CYC, 64, ISSUE cycles allowed before timeout abort; must be >= 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
run  in  1  level; 1 = execute, 0 = stop at next instruction boundary
imem_en  out  1  program memory read enable
imem_addr  out  PC_W  program memory address (= pc)
imem_data  in  16  read data, valid the cycle after imem_en; [15:12] opcode, [11:6] param1, [5:0] param2
parameter1  out  6  destination operand to units, registered
parameter2  out  6  source operand to units, registered
start  out  NUNITS  one-hot unit start, level, held until done
done  in  NUNITS  per-unit done
donefetch  out  1  one-cycle clear pulse to all units
pc  out  PC_W  current program counter
busy  out  1  1 when the state is not IDLE and not HALTED
halted  out  1  HALT executed
err_illegal  out  1  sticky illegal-opcode flag
err_timeout  out  1  sticky unit-timeout flag

Behaviour:
- Reset (rst=0, async): state IDLE; pc=0; ir=0; parameter1=parameter2=0; start=0; donefetch=0; imem_en=0; all flags 0; timeout counter 0.
- Opcode map:
  - 0 = NOP.
  - 1..NUNITS = unit (opcode-1).
  - 4'hF = HALT.
  - Anything else is illegal: it executes as a NOP and sets err_illegal.
- IDLE: if run=1, go to FETCH.
- FETCH (1 cycle): imem_en=1, imem_addr=pc; go to DECODE.
- DECODE (1 cycle): latch imem_data into ir. parameter1/parameter2 load from ir fields here and are held until the next DECODE.
  - NOP or illegal: pc<=pc+1, then FETCH if run=1, else IDLE.
  - HALT: go to HALTED; pc is not incremented.
  - Unit opcode: go to ISSUE.
- ISSUE: start[opcode-1]=1 every cycle while in ISSUE; the counter increments each cycle.
  - done[opcode-1]=1: drop start next cycle; go to CLEAR.
  - done bits of unselected units are ignored.
  - Counter reaches TMO_CYC-1 with no done: set err_timeout; go to CLEAR.
  - done and timeout in the same cycle: done wins; err_timeout stays unchanged.
- CLEAR (1 cycle): donefetch=1; start=0; counter=0; pc<=pc+1. Then FETCH if run=1, else IDLE.
- HALTED: halted=1; stays while run=1. When run=0: go to IDLE, halted=0, pc retained.
- run=0 mid-instruction: the current instruction completes through CLEAR, then the block goes to IDLE. It never aborts ISSUE.
- PC wraps from 2^PC_W-1 to 0 silently.
- Latency:
  - NOP: 2 cycles per instruction.
  - Unit instruction: 3 cycles plus the number of ISSUE cycles up to and including the one where done is seen.
- start is one-hot or zero at all times. donefetch is never high in the same cycle as any start bit.
- err flags are cleared only by reset.
- Reset mid-ISSUE: start drops asynchronously; donefetch stays 0. Units are cleared by their own reset.

Optional Feature:
Macro SINGLE_STEP_EN. When defined:
- Adds input step (1 bit) and state STEPWAIT.
- After each CLEAR, or DECODE of a NOP/illegal opcode, the block enters STEPWAIT instead of FETCH.
- It leaves STEPWAIT on the first cycle with step=1 and run=1, going to FETCH.
- run=0 in STEPWAIT goes to IDLE.

When not defined: no step port, no STEPWAIT state, behaviour exactly as above.

Test Plan:
- Reset, then run=1, imem[0]=16'h1000 (unit0, p1=0, p2=0), unit0 done 3 cycles after start rises -> start=4'b0001 for exactly 3 cycles; donefetch pulses 1 cycle; pc=1.
- imem[0]=16'h2083 (unit1, p1=2, p2=3) -> parameter1=2, parameter2=3 from the cycle after DECODE, held stable through ISSUE and CLEAR; done[0]=1 during ISSUE is ignored.
- imem[0..2]=16'h0000, 16'hE000, 16'hF000 -> NOPs take 2 cycles each; err_illegal=1 after the second; halted=1 with pc=2; run=0 gives IDLE with pc=2.
- Unit never raises done, TMO_CYC=64 -> start high 64 cycles; err_timeout=1; donefetch pulses; pc increments; next fetch proceeds.
- run dropped during ISSUE, done arrives 5 cycles later -> CLEAR completes, then IDLE; busy=0; pc advanced by 1.
- pc preset near wrap (PC_W=8, 255 NOPs then one more) -> pc reads 255 then 0; rst=0 asserted mid-ISSUE clears start and pc immediately.

Source files
------------

// File: rtl/instr_dispatch.sv
// instr_dispatch: instruction sequencer driving the unit start/done handshake.
// Fetches 16-bit words (opcode[15:12], param1[11:6], param2[5:0]) from a
// synchronous program memory, issues a held one-hot start to the selected
// unit, waits for its done (or a timeout), then pulses donefetch and advances.
// Optional feature: define SINGLE_STEP_EN to add the step input and the
// STEPWAIT state, which gates every instruction boundary on step=1.
module instr_dispatch #(
    parameter int PC_W    = 8,
    parameter int NUNITS  = 4,
    parameter int TMO_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic              imem_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_data,
    output logic [5:0]        parameter1,
    output logic [5:0]        parameter2,
    output logic [NUNITS-1:0] start,
    input  logic [NUNITS-1:0] done,
    output logic              donefetch,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              halted,
    output logic              err_illegal,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(TMO_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_CLEAR,
        S_HALTED
`ifdef SINGLE_STEP_EN
        , S_STEPWAIT
`endif
    } state_t;

    state_t           state, state_nxt, state_bound;
    logic [15:0]      ir;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       dec_op;
    logic [3:0]       ir_op;
    logic             dec_unit;
    logic             dec_halt;
    logic             done_sel;
    logic             tmo_hit;

    assign dec_op   = imem_data[15:12];
    assign ir_op    = ir[15:12];
    assign dec_halt = (dec_op == 4'hF);
    assign dec_unit = (dec_op != 4'h0) && (int'(dec_op) <= NUNITS);
    // start is already masked to the selected unit, so unselected done bits drop out
    assign done_sel = |(done & start);
    assign tmo_hit  = (cnt == CNT_W'(TMO_CYC - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection; state_bound is where an instruction boundary leads
    always_comb begin
        state_nxt = state;
`ifdef SINGLE_STEP_EN
        state_bound = run ? S_STEPWAIT : S_IDLE;
`else
        state_bound = run ? S_FETCH : S_IDLE;
`endif
        case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (dec_halt)      state_nxt = S_HALTED;
                else if (dec_unit) state_nxt = S_ISSUE;
                else               state_nxt = state_bound;
            end
            S_ISSUE:  if (done_sel || tmo_hit) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = state_bound;
            S_HALTED: if (!run) state_nxt = S_IDLE;
`ifdef SINGLE_STEP_EN
            S_STEPWAIT: begin
                if (!run)      state_nxt = S_IDLE;
                else if (step) state_nxt = S_FETCH;
            end
`endif
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; start follows the state so reset drops it at once
    always_comb begin
        imem_en   = (state == S_FETCH);
        imem_addr = pc;
        donefetch = (state == S_CLEAR);
        halted    = (state == S_HALTED);
        busy      = (state != S_IDLE) && (state != S_HALTED);
        start     = '0;
        for (int unsigned i = 0; i < NUNITS; i++) begin
            start[i] = (state == S_ISSUE) && (ir_op == 4'(i + 1));
        end
    end

    // Datapath: instruction register, operands, pc, timeout counter, sticky flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= '0;
            ir          <= '0;
            parameter1  <= '0;
            parameter2  <= '0;
            cnt         <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                S_DECODE: begin
                    ir         <= imem_data;
                    parameter1 <= imem_data[11:6];
                    parameter2 <= imem_data[5:0];
                    if (!dec_unit && !dec_halt) begin
                        pc <= pc + PC_W'(1);
                        if (dec_op != 4'h0) err_illegal <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (tmo_hit && !done_sel) err_timeout <= 1'b1;
                end
                S_CLEAR: begin
                    cnt <= '0;
                    pc  <= pc + PC_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_dispatch.sv
// tb_instr_dispatch: directed plus randomized checks of instr_dispatch against
// an instruction-level model (per-instruction latency, pc and flag rules).
module tb_instr_dispatch;

    localparam int PC_W    = 8;
    localparam int NUNITS  = 4;
    localparam int TMO_CYC = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              imem_en;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_data = '0;
    logic [5:0]        parameter1, parameter2;
    logic [NUNITS-1:0] start;
    logic [NUNITS-1:0] done = '0;
    logic              donefetch, busy, halted, err_illegal, err_timeout;
    logic [PC_W-1:0]   pc;
`ifdef SINGLE_STEP_EN
    logic              step = 1'b1;
`endif

    instr_dispatch #(.PC_W(PC_W), .NUNITS(NUNITS), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .rst(rst), .run(run),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .parameter1(parameter1), .parameter2(parameter2),
        .start(start), .done(done), .donefetch(donefetch), .pc(pc),
        .busy(busy), .halted(halted),
        .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Synchronous program memory
    logic [15:0] mem [0:255];
    always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr];

    // Unit responders: done rises on the lat-th cycle of a held start.
    // noise: 0 quiet, 1 random, 2 all ones on units that are not started.
    int lat  [NUNITS];
    int icnt [NUNITS];
    int noise = 0;
    always @(negedge clk) begin
        for (int i = 0; i < NUNITS; i++) begin
            if (start[i] === 1'b1) begin
                icnt[i]++;
                done[i] = (icnt[i] >= lat[i]);
            end else begin
                icnt[i] = 0;
                done[i] = (noise == 2) ? 1'b1 :
                          (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction-level model state
    int m_pc;
    bit m_ill, m_tmo;

    task automatic do_reset();
        rst   = 1'b0;
        run   = 1'b0;
        noise = 0;
        for (int i = 0; i < NUNITS; i++) lat[i] = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_start", start, 0);
        chk("rst_df", donefetch, 0);
        chk("rst_en", imem_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ill", err_illegal, 0);
        chk("rst_tmo", err_timeout, 0);
        chk("rst_p1", parameter1, 0);
        chk("rst_p2", parameter2, 0);
        rst   = 1'b1;
        m_pc  = 0;
        m_ill = 0;
        m_tmo = 0;
    endtask

    // Called at the negedge of the FETCH cycle of the instruction at m_pc.
    // drop_at>0 drops run on that ISSUE cycle.
    task automatic exec_one(input int drop_at = 0);
        logic [15:0] w;
        logic [3:0]  op;
        int          u, n;
        logic [31:0] onehot;
        w  = mem[m_pc];
        op = w[15:12];
        chk("fetch_en", imem_en, 1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_start", start, 0);
        chk("fetch_busy", busy, 1);
        @(negedge clk);
        chk("dec_start", start, 0);
        chk("dec_df", donefetch, 0);
        if (op == 4'h0 || (int'(op) > NUNITS && op != 4'hF)) begin
            if (op != 4'h0) m_ill = 1;
            m_pc = (m_pc + 1) % 256;
            @(negedge clk);
            chk("nop_pc", pc, m_pc);
            chk("nop_ill", err_illegal, m_ill);
        end else if (op == 4'hF) begin
            @(negedge clk);
            chk("halt_flag", halted, 1);
            chk("halt_pc", pc, m_pc);
            chk("halt_busy", busy, 0);
        end else begin
            u = int'(op) - 1;
            n = (lat[u] < TMO_CYC) ? lat[u] : TMO_CYC;
            onehot = 32'd1 << u;
            @(negedge clk);
            chk("issue_p1", parameter1, w[11:6]);
            chk("issue_p2", parameter2, w[5:0]);
            for (int k = 1; k <= n; k++) begin
                chk("issue_start", start, onehot);
                chk("issue_df", donefetch, 0);
                if (k == drop_at) run = 1'b0;
                @(negedge clk);
            end
            chk("clr_start", start, 0);
            chk("clr_df", donefetch, 1);
            chk("clr_p1", parameter1, w[11:6]);
            chk("clr_p2", parameter2, w[5:0]);
            if (lat[u] > TMO_CYC) m_tmo = 1;
            m_pc = (m_pc + 1) % 256;
            @(negedge clk);
            chk("post_pc", pc, m_pc);
            chk("post_tmo", err_timeout, m_tmo);
            chk("post_df", donefetch, 0);
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int sel;
        rst = 1'b0;
        run = 1'b0;
        clear_mem();

        // Unit 0 with done on its 3rd start cycle
        do_reset();
        mem[0] = 16'h1000;
        lat[0] = 3;
        run = 1'b1;
        @(negedge clk);
        exec_one();

        // Unit 1 operands; other done lines held high must be ignored
        do_reset();
        clear_mem();
        mem[0] = 16'h2083;
        lat[1] = 4;
        noise  = 2;
        run = 1'b1;
        @(negedge clk);
        exec_one();
        noise = 0;

        // NOP, illegal, HALT, then stop
        do_reset();
        clear_mem();
        mem[0] = 16'h0000;
        mem[1] = 16'hE000;
        mem[2] = 16'hF000;
        run = 1'b1;
        @(negedge clk);
        exec_one();
        exec_one();
        exec_one();
        @(negedge clk);
        chk("halt_hold", halted, 1);
        run = 1'b0;
        @(negedge clk);
        chk("unhalt_flag", halted, 0);
        chk("unhalt_busy", busy, 0);
        chk("unhalt_pc", pc, 2);

        // Timeout, then the next instruction proceeds
        do_reset();
        clear_mem();
        mem[0] = 16'h1000;
        lat[0] = 1000;
        run = 1'b1;
        @(negedge clk);
        exec_one();
        lat[0] = 2;
        exec_one();

        // run dropped on ISSUE cycle 2, done 5 cycles later
        do_reset();
        clear_mem();
        mem[0] = 16'h3000;
        lat[2] = 7;
        run = 1'b1;
        @(negedge clk);
        exec_one(2);
        chk("stop_busy", busy, 0);
        @(negedge clk);
        chk("stop_idle_en", imem_en, 0);
        chk("stop_idle_busy", busy, 0);
        chk("stop_idle_pc", pc, 1);

        // pc wrap after 256 NOPs, then reset in the middle of ISSUE
        do_reset();
        clear_mem();
        run = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) exec_one();
        chk("wrap_pc", pc, 0);
        mem[1] = 16'h1000;
        lat[0] = 50;
        exec_one();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_start", start, 1);
        rst = 1'b0;
        #1;
        chk("async_start", start, 0);
        chk("async_pc", pc, 0);
        chk("async_df", donefetch, 0);

        // Random program ending in HALT
        do_reset();
        clear_mem();
        for (int a = 0; a < 60; a++) begin
            sel = $urandom_range(0, 9);
            w = 16'($urandom_range(0, 4095));
            if (sel < 2)       w[15:12] = 4'h0;
            else if (sel == 2) w[15:12] = 4'($urandom_range(NUNITS + 1, 14));
            else               w[15:12] = 4'($urandom_range(1, NUNITS));
            mem[a] = w;
        end
        mem[60] = 16'hF000;
        noise = 1;
        run = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 61; i++) begin
            for (int j = 0; j < NUNITS; j++)
                lat[j] = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(1, 8);
            w = mem[m_pc];
            exec_one();
            if (w[15:12] == 4'hF) break;
        end
        chk("rand_halted", halted, 1);
        chk("rand_pc", pc, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
